// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the FD hazard / sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        DRAIN      = 3'd1,
        PUSH_PC    = 3'd2,
        PUSH_FLAGS = 3'd3,
        VECTOR     = 3'd4,
        RTI_FLAGS  = 3'd5,
        RTI_PC     = 3'd6
    } pipe_state_t;

    localparam logic [1:0] PCSEL_INC    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_VECTOR = 2'b10;
    localparam logic [1:0] PCSEL_POP    = 2'b11;

    // Wide enough for DRAIN_CYCLES-1 with DRAIN_CYCLES up to 7.
    localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/fd_drain_counter.sv
// Loadable down-counter for the interrupt drain window; pauses while dec=0.
// zero is asserted when the count is zero at the end of this cycle.
module fd_drain_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = DRAIN_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0) || (dec && count == W'(1));

endmodule

// File: rtl/fd_hazard_controller.sv
// FD/PC sequencer: Mealy outputs, same-cycle response; mem_busy freezes the pipe and holds drain/push steps.
// Optional FD_PERF_CNT_EN adds saturating stall_count / flush_count outputs.
module fd_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] VECTOR_ADDR  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        int_req,
    input  logic        rti_dec,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic [15:0] pc_vector,
    output logic        fd_en,
    output logic        fd_hold,
    output logic        de_bubble,
    output logic        pipe_freeze,
    output logic        push_pc,
    output logic        push_flags,
    output logic        pop_flags,
    output logic        int_ack
`ifdef FD_PERF_CNT_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    pipe_state_t state, state_nxt;
    logic        int_pending;
    logic        cnt_load, cnt_dec, cnt_zero;

    assign pc_vector = VECTOR_ADDR;

    fd_drain_counter #(.W(DRAIN_CNT_W)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (DRAIN_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        pc_sel      = PCSEL_INC;
        fd_en       = 1'b0;
        fd_hold     = 1'b0;
        de_bubble   = 1'b0;
        pipe_freeze = 1'b0;
        push_pc     = 1'b0;
        push_flags  = 1'b0;
        pop_flags   = 1'b0;
        int_ack     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        if (!reset) begin
            pipe_freeze = mem_busy;
            unique case (state)
                RUN: begin
                    if (mem_busy) begin
                        fd_en   = 1'b1;
                        fd_hold = 1'b1;
                    end else if (branch_taken) begin
                        pc_sel    = PCSEL_BRANCH;
                        pc_en     = 1'b1;
                        de_bubble = 1'b1;
                    end else if (int_pending || int_req) begin
                        // A request seen this very cycle is accepted immediately.
                        int_ack   = 1'b1;
                        cnt_load  = 1'b1;
                        state_nxt = DRAIN;
                    end else if (rti_dec) begin
                        state_nxt = RTI_FLAGS;
                    end else if (load_use) begin
                        fd_en     = 1'b1;
                        fd_hold   = 1'b1;
                        de_bubble = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        fd_en = 1'b1;
                    end
                end
                DRAIN: begin
                    cnt_dec = !mem_busy;
                    if (!mem_busy && cnt_zero) state_nxt = PUSH_PC;
                end
                PUSH_PC: begin
                    push_pc = 1'b1;
                    if (!mem_busy) state_nxt = PUSH_FLAGS;
                end
                PUSH_FLAGS: begin
                    push_flags = 1'b1;
                    if (!mem_busy) state_nxt = VECTOR;
                end
                VECTOR: begin
                    pc_sel    = PCSEL_VECTOR;
                    pc_en     = 1'b1;
                    state_nxt = RUN;
                end
                RTI_FLAGS: begin
                    pop_flags = 1'b1;
                    state_nxt = RTI_PC;
                end
                RTI_PC: begin
                    pc_sel    = PCSEL_POP;
                    pc_en     = 1'b1;
                    state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            int_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            int_pending <= int_ack ? 1'b0 : (int_pending | int_req);
        end
    end

`ifdef FD_PERF_CNT_EN
    // Only a branch flush drives bubble and PC update together; only load-use pairs bubble with hold.
    logic stall_inc, flush_inc;
    assign stall_inc = (fd_hold & de_bubble) | pipe_freeze;
    assign flush_inc = de_bubble & pc_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            if (flush_inc && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fd_hazard_controller.sv
// Bench for fd_hazard_controller: directed scenarios plus random traffic against a step-queue model.
module tb_fd_hazard_controller;

    localparam int DC = 3;
    localparam int S_DRAIN = 0, S_PUSH_PC = 1, S_PUSH_FL = 2, S_VEC = 3, S_POPF = 4, S_POPPC = 5;

    logic clk, reset, load_use, branch_taken, mem_busy, int_req, rti_dec;
    logic pc_en, fd_en, fd_hold, de_bubble, pipe_freeze, push_pc, push_flags, pop_flags, int_ack;
    logic [1:0]  pc_sel;
    logic [15:0] pc_vector;
    logic [10:0] obs;
    logic [10:0] exp_vec;

    int checks = 0;
    int errors = 0;
    int q[$];
    bit pend = 0;

    fd_hazard_controller #(.DRAIN_CYCLES(DC), .VECTOR_ADDR(16'h0000)) dut (
        .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .int_req(int_req), .rti_dec(rti_dec),
        .pc_en(pc_en), .pc_sel(pc_sel), .pc_vector(pc_vector), .fd_en(fd_en),
        .fd_hold(fd_hold), .de_bubble(de_bubble), .pipe_freeze(pipe_freeze),
        .push_pc(push_pc), .push_flags(push_flags), .pop_flags(pop_flags), .int_ack(int_ack)
    );

    assign obs = {pc_en, pc_sel, fd_en, fd_hold, de_bubble, pipe_freeze,
                  push_pc, push_flags, pop_flags, int_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs at the falling edge, then predicts the outputs.
    // The model keeps the remaining entry/exit steps as a queue; empty queue means RUN.
    task automatic drive(input bit r, input bit lu, input bit br, input bit mb, input bit ir, input bit rti);
        bit a_pen, a_fe, a_fh, a_db, a_pf, a_pp, a_pfl, a_pop, a_ack;
        bit [1:0] a_sel;
        int cur;
        @(negedge clk);
        reset = r; load_use = lu; branch_taken = br; mem_busy = mb; int_req = ir; rti_dec = rti;
        #1;
        {a_pen, a_fe, a_fh, a_db, a_pf, a_pp, a_pfl, a_pop, a_ack} = '0;
        a_sel = 2'b00;
        if (r) begin
            q.delete();
            pend = 0;
        end else begin
            a_pf = mb;
            if (q.size() == 0) begin
                if (mb) begin
                    a_fe = 1; a_fh = 1;
                end else if (br) begin
                    a_sel = 2'b01; a_pen = 1; a_db = 1;
                end else if (pend || ir) begin
                    a_ack = 1;
                    for (int k = 0; k < ((DC > 1) ? DC - 1 : 1); k++) q.push_back(S_DRAIN);
                    q.push_back(S_PUSH_PC); q.push_back(S_PUSH_FL); q.push_back(S_VEC);
                end else if (rti) begin
                    q.push_back(S_POPF); q.push_back(S_POPPC);
                end else if (lu) begin
                    a_fe = 1; a_fh = 1; a_db = 1;
                end else begin
                    a_pen = 1; a_fe = 1;
                end
            end else begin
                cur = q[0];
                case (cur)
                    S_PUSH_PC: a_pp = 1;
                    S_PUSH_FL: a_pfl = 1;
                    S_VEC:     begin a_sel = 2'b10; a_pen = 1; end
                    S_POPF:    a_pop = 1;
                    S_POPPC:   begin a_sel = 2'b11; a_pen = 1; end
                    default:   ;
                endcase
                if (!(mb && (cur == S_DRAIN || cur == S_PUSH_PC || cur == S_PUSH_FL)))
                    void'(q.pop_front());
            end
            pend = a_ack ? 1'b0 : (pend | ir);
        end
        exp_vec = {a_pen, a_sel, a_fe, a_fh, a_db, a_pf, a_pp, a_pfl, a_pop, a_ack};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), 0);
            checks++;
            if (obs !== 11'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, obs, 11'b0);
            end
        end
        checks++;
        if (pc_vector !== 16'h0000) begin
            errors++;
            $display("FAIL pc_vector: got %h expected %h", pc_vector, 16'h0000);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, exp_vec);
        end
    endtask

    task automatic test_load_use();
        bit [2:0] pat = 3'b010;
        for (int i = 0; i < 3; i++) begin
            drive(0, pat[i], 0, 0, 0, 0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL load_use cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_branch();
        drive(0, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_vec || pc_sel !== 2'b01 || fd_hold !== 1'b0 || fd_en !== 1'b0) begin
            errors++;
            $display("FAIL branch_with_load_use: got %b expected %b", obs, exp_vec);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL branch_after: got %b expected %b", obs, exp_vec);
        end
    endtask

    task automatic test_interrupt();
        int ack_i = -100, vec_i = -50;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, (i == 0), 0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL int_entry cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
            if (int_ack) ack_i = i;
            if (pc_en && pc_sel == 2'b10) vec_i = i;
        end
        checks++;
        if (vec_i - ack_i !== 5) begin
            errors++;
            $display("FAIL int_vector_latency: got %0d expected %0d", vec_i - ack_i, 5);
        end
    endtask

    task automatic test_drain_freeze();
        int ack_i = -100, vec_i = -50;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, (i == 2 || i == 3), (i == 0), 0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL drain_freeze cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
            if (int_ack) ack_i = i;
            if (pc_en && pc_sel == 2'b10) vec_i = i;
        end
        checks++;
        if (vec_i - ack_i !== 7) begin
            errors++;
            $display("FAIL drain_freeze_latency: got %0d expected %0d", vec_i - ack_i, 7);
        end
    endtask

    task automatic test_rti();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, (i == 0));
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL rti cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int acks = 0;
        for (int i = 0; i < 8; i++) begin
            drive((i == 2 || i == 3), 0, 0, 0, (i == 0), 0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_mid_drain cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
            if (i >= 4 && int_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL reset_no_reack: got %0d acks expected %0d", acks, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 5));
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1; load_use = 0; branch_taken = 0; mem_busy = 0; int_req = 0; rti_dec = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_interrupt();
        test_drain_freeze();
        test_rti();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
